// File: rtl/detect_window_pkg.sv
// Shared types and default widths for the windowed pattern detector.
// Imported by pattern_shift_match and detect_window_ctrl.
package detect_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_PAT_W = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_WIN_W = 16;

endpackage

// File: rtl/pattern_shift_match.sv
// Serial shift register, fill counter and pattern comparator.
// DETECT_WINDOW_OVERLAP_EN: keep fill full after a match (overlapping hits).
module pattern_shift_match
    import detect_window_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             ina_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic             match_o
);

    localparam int unsigned FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
`ifdef DETECT_WINDOW_OVERLAP_EN
    localparam logic [FW-1:0] FILL_AFTER = FULL;
`else
    localparam logic [FW-1:0] FILL_AFTER = '0;
`endif

    logic [PAT_W-1:0] sh_q, sh_d, sh_nxt;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;

    // Next shift value, saturating fill and match decision.
    always_comb begin
        sh_nxt   = {sh_q[PAT_W-2:0], ina_i};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        match_o  = en_i && (fill_inc == FULL) && (sh_nxt == pat_i);
        sh_d     = sh_q;
        fill_d   = fill_q;
        if (clr_i) begin
            sh_d   = '0;
            fill_d = '0;
        end else if (en_i) begin
            sh_d   = sh_nxt;
            fill_d = match_o ? FILL_AFTER : fill_inc;
        end
    end

    // Shift register and fill counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q   <= '0;
            fill_q <= '0;
        end else begin
            sh_q   <= sh_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/detect_window_ctrl.sv
// Windowed serial-pattern detection controller: FSM, window and hit counters.
// DETECT_WINDOW_OVERLAP_EN selects overlapping matches in pattern_shift_match.
module detect_window_ctrl
    import detect_window_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ina,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [WIN_W-1:0] wlen_q, wlen_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             accept, arm, run, match;

    pattern_shift_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (arm),
        .en_i    (run),
        .ina_i   (ina),
        .pat_i   (pat_q),
        .match_o (match)
    );

    // Next-state and control decode; start only honoured in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        arm     = 1'b0;
        run     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                arm     = 1'b1;
                busy    = 1'b1;
                state_d = (wlen_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                run  = 1'b1;
                busy = 1'b1;
                if (wcnt_q == WIN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture, window countdown, saturating hits.
    always_comb begin
        pat_d  = accept ? pat : pat_q;
        wlen_d = accept ? win_len : wlen_q;
        wcnt_d = wcnt_q;
        cnt_d  = cnt_q;
        hit_d  = run & match;
        if (arm) begin
            wcnt_d = wlen_q;
            cnt_d  = '0;
        end else if (run) begin
            wcnt_d = wcnt_q - WIN_W'(1);
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration, counters and hit pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            wlen_q <= '0;
            wcnt_q <= '0;
            cnt_q  <= '0;
            hit_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            wlen_q <= wlen_d;
            wcnt_q <= wcnt_d;
            cnt_q  <= cnt_d;
            hit_q  <= hit_d;
        end
    end

    assign hit     = hit_q;
    assign hit_cnt = cnt_q;

endmodule
